// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver.
//
// Receives frames of 1 start bit (0), 8 data bits LSB first and 1 stop bit (1)
// on an asynchronous, idle-high line. The line is brought into the clk domain
// through a two-flop synchronizer. The start bit is validated at its middle,
// and every later bit is sampled one full bit period after the previous one.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset
//   miso       asynchronous serial input, idle high
//   rx_data    last correctly framed byte (held until the next good frame)
//   rx_valid   one-cycle pulse: rx_data was updated this cycle
//   frame_err  one-cycle pulse: the stop bit was sampled low
//   busy       high whenever the receiver is not idle
//
// Output semantics: rx_valid and frame_err are registered, mutually exclusive
// pulses with at most one per frame. There is no ready/backpressure; a new
// byte overwrites rx_data whether or not the previous one was consumed.
//
// Latency: if the start bit first appears on miso in cycle T, rx_valid is high
// in cycle T + 3 + HALF + 9*CLKS_PER_BIT.
module uart_rx #(
    parameter int CLKS_PER_BIT = 1      // clock cycles per serial bit, 1..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       miso,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    // Distance from the start-bit edge to the start-bit middle, in cycles.
    localparam int         HALF_I = (CLKS_PER_BIT - 1) / 2;
    localparam logic [7:0] HALF   = 8'(HALF_I);
    // Last baud_cnt value of a bit period; a bit is sampled on this count.
    localparam logic [7:0] LAST   = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t     state;
    logic       sync_q1;     // first synchronizer stage
    logic       s;           // synchronized line; the only view of miso used
    logic [7:0] baud_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shift_reg;

    assign busy = (state != IDLE);

    // Synchronizer. Both flops reset high so the line reads idle while and
    // right after rst is asserted, whatever miso is doing.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b1;
            s       <= 1'b1;
        end else begin
            sync_q1 <= miso;
            s       <= sync_q1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= 8'd0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'd0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            // Pulses last one cycle unless re-asserted below.
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (!s) begin
                        bit_idx <= 3'd0;
                        if (HALF == 8'd0) begin
                            // The start-bit middle is this very cycle, so
                            // the start bit counts as already validated.
                            state    <= DATA;
                            baud_cnt <= 8'd0;
                        end else begin
                            // This cycle is count 0 of the start bit.
                            state    <= START;
                            baud_cnt <= 8'd1;
                        end
                    end
                end

                START: begin
                    // baud_cnt runs 1..HALF here, so != is the same as <.
                    if (baud_cnt != HALF) begin
                        baud_cnt <= baud_cnt + 8'd1;
                    end else if (!s) begin
                        state    <= DATA;
                        baud_cnt <= 8'd0;
                        bit_idx  <= 3'd0;
                    end else begin
                        // Line went back high before mid-bit: a glitch.
                        state    <= IDLE;
                        baud_cnt <= 8'd0;
                    end
                end

                DATA: begin
                    if (baud_cnt != LAST) begin
                        baud_cnt <= baud_cnt + 8'd1;
                    end else begin
                        // LSB arrives first, so shift right and insert at
                        // the MSB; after 8 samples bit 0 sits at [0].
                        shift_reg <= {s, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 3'd1;
                        baud_cnt  <= 8'd0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end
                end

                STOP: begin
                    if (baud_cnt != LAST) begin
                        baud_cnt <= baud_cnt + 8'd1;
                    end else begin
                        baud_cnt <= 8'd0;
                        if (s) begin
                            rx_data  <= shift_reg;
                            rx_valid <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            // rx_data keeps the previous good byte.
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end
                end

                WAIT_HIGH: begin
                    // A held-low line (break) must not look like a new start
                    // bit, so wait for the line to return high first.
                    if (s) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state    <= IDLE;
                    baud_cnt <= 8'd0;
                    bit_idx  <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx. Two instances run side by side: dut_a with
// CLKS_PER_BIT=1 and dut_b with CLKS_PER_BIT=16.
// Expected pulses come from a frame-level model: each frame driven by the
// bench pushes {expected cycle, is_error, data} into that instance's queue.
// The expected cycle is start cycle + 3 + HALF + 9*CLKS_PER_BIT, and the
// expected rx_data is the last good byte seen, or 0 after a reset.
module tb_uart_rx;
  localparam int CPB_A = 1;
  localparam int CPB_B = 16;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1;
  logic       rst_b = 1'b1;
  logic       miso_a = 1'b1;
  logic       miso_b = 1'b1;
  logic [7:0] rx_data_a, rx_data_b;
  logic       rx_valid_a, rx_valid_b;
  logic       frame_err_a, frame_err_b;
  logic       busy_a, busy_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Scoreboard entries: {cycle[31:0], is_error, data[7:0]}
  logic [40:0] exp_q_a[$];
  logic [40:0] exp_q_b[$];
  logic [7:0]  exp_data_a = 8'h00;
  logic [7:0]  exp_data_b = 8'h00;
  logic        rst_last_a = 1'b1;
  logic        rst_last_b = 1'b1;

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    int         low_extra;
    int         gap_high;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs[6];

  uart_rx #(.CLKS_PER_BIT(CPB_A)) dut_a (
    .clk(clk), .rst(rst_a), .miso(miso_a), .rx_data(rx_data_a),
    .rx_valid(rx_valid_a), .frame_err(frame_err_a), .busy(busy_a)
  );

  uart_rx #(.CLKS_PER_BIT(CPB_B)) dut_b (
    .clk(clk), .rst(rst_b), .miso(miso_b), .rx_data(rx_data_b),
    .rx_valid(rx_valid_b), .frame_err(frame_err_b), .busy(busy_b)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- compare helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic set_miso(input int sel, input logic v);
    if (sel == 0) miso_a = v;
    else          miso_b = v;
  endtask

  task automatic hold(input int sel, input logic v, input int n);
    repeat (n) begin
      @(posedge clk); #1;
      set_miso(sel, v);
    end
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input logic stop_ok,
                            input int low_extra, input int gap_high,
                            input logic [7:0] exp_d, input logic exp_err);
    int cpb;
    int half;
    int t0;
    logic [40:0] ev;
    cpb  = (sel == 0) ? CPB_A : CPB_B;
    half = (cpb - 1) / 2;
    @(posedge clk); #1;
    set_miso(sel, 1'b0);
    t0 = cyc;
    ev = {32'(t0 + 3 + half + 9 * cpb), exp_err, exp_d};
    if (sel == 0) exp_q_a.push_back(ev);
    else          exp_q_b.push_back(ev);
    hold(sel, 1'b0, cpb - 1);
    for (int i = 0; i < 8; i++) hold(sel, d[i], cpb);
    hold(sel, stop_ok, cpb);
    hold(sel, 1'b0, low_extra);
    hold(sel, 1'b1, gap_high);
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin : mon_a
    logic [40:0] head;
    if (rst_last_a) begin
      exp_data_a = 8'h00;
      check("a_busy_in_reset", 32'(busy_a), 32'd0);
    end
    check("a_exclusive", 32'(rx_valid_a & frame_err_a), 32'd0);
    if (rx_valid_a || frame_err_a) begin
      if (exp_q_a.size() == 0) begin
        check("a_unexpected_pulse", 32'({rx_valid_a, frame_err_a}), 32'd0);
      end else begin
        head = exp_q_a.pop_front();
        check("a_pulse_cycle", 32'(cyc), head[40:9]);
        check("a_pulse_kind", 32'(frame_err_a), 32'(head[8]));
        if (!head[8]) exp_data_a = head[7:0];
      end
    end else if (exp_q_a.size() != 0 && int'(exp_q_a[0][40:9]) < cyc) begin
      head = exp_q_a.pop_front();
      check("a_missing_pulse", 32'(cyc), head[40:9]);
    end
    check("a_rx_data", 32'(rx_data_a), 32'(exp_data_a));
    rst_last_a = rst_a;
  end

  always @(negedge clk) begin : mon_b
    logic [40:0] head;
    if (rst_last_b) begin
      exp_data_b = 8'h00;
      check("b_busy_in_reset", 32'(busy_b), 32'd0);
    end
    check("b_exclusive", 32'(rx_valid_b & frame_err_b), 32'd0);
    if (rx_valid_b || frame_err_b) begin
      if (exp_q_b.size() == 0) begin
        check("b_unexpected_pulse", 32'({rx_valid_b, frame_err_b}), 32'd0);
      end else begin
        head = exp_q_b.pop_front();
        check("b_pulse_cycle", 32'(cyc), head[40:9]);
        check("b_pulse_kind", 32'(frame_err_b), 32'(head[8]));
        if (!head[8]) exp_data_b = head[7:0];
      end
    end else if (exp_q_b.size() != 0 && int'(exp_q_b[0][40:9]) < cyc) begin
      head = exp_q_b.pop_front();
      check("b_missing_pulse", 32'(cyc), head[40:9]);
    end
    check("b_rx_data", 32'(rx_data_b), 32'(exp_data_b));
    rst_last_b = rst_b;
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] last_ok;
    logic [7:0] c3;
    logic [7:0] rd;
    logic       ok;

    vecs[0] = '{data: 8'hA5, stop_ok: 1'b1, low_extra: 0, gap_high: 3, exp_data: 8'hA5, exp_err: 1'b0};
    vecs[1] = '{data: 8'h00, stop_ok: 1'b1, low_extra: 0, gap_high: 0, exp_data: 8'h00, exp_err: 1'b0};
    vecs[2] = '{data: 8'hFF, stop_ok: 1'b1, low_extra: 0, gap_high: 0, exp_data: 8'hFF, exp_err: 1'b0};
    vecs[3] = '{data: 8'h3C, stop_ok: 1'b1, low_extra: 0, gap_high: 2, exp_data: 8'h3C, exp_err: 1'b0};
    vecs[4] = '{data: 8'h96, stop_ok: 1'b0, low_extra: 3, gap_high: 1, exp_data: 8'h96, exp_err: 1'b1};
    vecs[5] = '{data: 8'h7E, stop_ok: 1'b1, low_extra: 0, gap_high: 4, exp_data: 8'h7E, exp_err: 1'b0};

    // Reset: miso toggles while rst is high and must be ignored.
    repeat (2) @(posedge clk);
    #1; miso_a = 1'b0; miso_b = 1'b0;
    @(posedge clk); #1; miso_a = 1'b1; miso_b = 1'b1;
    @(negedge clk);
    check("a_reset_rx_data", 32'(rx_data_a), 32'h00);
    check("a_reset_rx_valid", 32'(rx_valid_a), 32'd0);
    check("a_reset_frame_err", 32'(frame_err_a), 32'd0);
    check("a_reset_busy", 32'(busy_a), 32'd0);
    check("b_reset_rx_data", 32'(rx_data_b), 32'h00);
    check("b_reset_rx_valid", 32'(rx_valid_b), 32'd0);
    check("b_reset_frame_err", 32'(frame_err_b), 32'd0);
    check("b_reset_busy", 32'(busy_b), 32'd0);
    @(posedge clk); #1; rst_a = 1'b0; rst_b = 1'b0;
    hold(0, 1'b1, 4);

    // Table-driven frames on dut_a (A5 loopback, back-to-back 00/FF/3C, ...).
    last_ok = 8'h00;
    for (int i = 0; i < 6; i++) begin
      send_frame(0, vecs[i].data, vecs[i].stop_ok, vecs[i].low_extra, vecs[i].gap_high,
                 vecs[i].exp_data, vecs[i].exp_err);
      if (!vecs[i].exp_err) last_ok = vecs[i].exp_data;
    end
    hold(0, 1'b1, 20);
    check("a_table_last_data", 32'(rx_data_a), 32'(last_ok));

    // Break: 55 with a low stop bit, line held low 40 cycles.
    send_frame(0, 8'h55, 1'b0, 0, 0, 8'h55, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1; miso_a = 1'b0;
      @(negedge clk);
      check("a_busy_during_break", 32'(busy_a), 32'd1);
    end
    hold(0, 1'b1, 6);
    @(negedge clk);
    check("a_busy_after_break", 32'(busy_a), 32'd0);
    check("a_data_after_break", 32'(rx_data_a), 32'(last_ok));

    // Reset during data bit 4 of C3, held through the rest of that frame.
    c3 = 8'hC3;
    @(posedge clk); #1; miso_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1; miso_a = c3[i];
      if (i == 4) rst_a = 1'b1;
    end
    @(posedge clk); #1; miso_a = 1'b1;
    @(posedge clk); #1; rst_a = 1'b0;
    hold(0, 1'b1, 4);
    @(negedge clk);
    check("a_busy_after_abort", 32'(busy_a), 32'd0);
    check("a_data_after_abort", 32'(rx_data_a), 32'h00);
    send_frame(0, 8'h5A, 1'b1, 0, 4, 8'h5A, 1'b0);
    hold(0, 1'b1, 4);
    check("a_data_after_5a", 32'(rx_data_a), 32'h5A);

    // dut_b: 5-cycle glitch must return to idle with no pulse.
    hold(1, 1'b1, 4);
    hold(1, 1'b0, 5);
    @(posedge clk); #1; miso_b = 1'b1;
    @(negedge clk);
    check("b_busy_in_glitch", 32'(busy_b), 32'd1);
    hold(1, 1'b1, 20);
    @(negedge clk);
    check("b_busy_after_glitch", 32'(busy_b), 32'd0);
    check("b_data_after_glitch", 32'(rx_data_b), 32'h00);

    // dut_b: full frame 81 (rx_valid expected at T+3+7+144).
    send_frame(1, 8'h81, 1'b1, 0, 16, 8'h81, 1'b0);
    hold(1, 1'b1, 16);
    check("b_data_81", 32'(rx_data_b), 32'h81);

    // Randomized frames against the frame-level model.
    for (int i = 0; i < 30; i++) begin
      rd = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 4) != 0);
      if (ok) send_frame(0, rd, 1'b1, 0, $urandom_range(0, 3), rd, 1'b0);
      else    send_frame(0, rd, 1'b0, $urandom_range(0, 5), $urandom_range(1, 3), rd, 1'b1);
    end
    for (int i = 0; i < 6; i++) begin
      rd = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 3) != 0);
      if (ok) send_frame(1, rd, 1'b1, 0, $urandom_range(0, 32), rd, 1'b0);
      else    send_frame(1, rd, 1'b0, $urandom_range(0, 48), $urandom_range(1, 32), rd, 1'b1);
    end

    hold(0, 1'b1, 200);
    hold(1, 1'b1, 20);
    check("a_queue_drained", 32'(exp_q_a.size()), 32'd0);
    check("b_queue_drained", 32'(exp_q_b.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
